ahb_arbiter: RTL and testbench

AHB_ARBITER -- requirements
Module: ahb_arbiter

---
 rtl/ahb_arbiter.sv | 112 +++++++++++
 tb/tb_ahb_arbiter.sv | 202 ++++++++++++++++++++
 2 files changed

// File: rtl/ahb_arbiter.sv
// Round-robin AHB bus arbiter with a per-master hold limit and address/data phase muxing.
// Grant state only advances on hready=1 edges; write data follows the data-phase owner.
module ahb_arbiter #(
  parameter int unsigned ADDR_WIDTH = 16,
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned MAT_NUM    = 4,
  parameter int unsigned MAX_HOLD   = 16,
  localparam int unsigned MW        = $clog2(MAT_NUM),
  localparam int unsigned HW        = $clog2(MAX_HOLD + 1)
) (
  input  logic                  hclk,
  input  logic                  hrst,
  input  logic [MAT_NUM-1:0]    hbusreq,
  input  logic [ADDR_WIDTH-1:0] haddr_m  [0:MAT_NUM-1],
  input  logic [1:0]            htrans_m [0:MAT_NUM-1],
  input  logic [MAT_NUM-1:0]    hwrite_m,
  input  logic [DATA_WIDTH-1:0] hwdata_m [0:MAT_NUM-1],
  input  logic                  hready,
  output logic [MAT_NUM-1:0]    hgrant,
  output logic [MW-1:0]         hmaster,
  output logic [ADDR_WIDTH-1:0] haddr,
  output logic [1:0]            htrans,
  output logic                  hwrite,
  output logic [DATA_WIDTH-1:0] hwdata
);

  typedef enum logic {StPark, StOwn} state_e;

  state_e              state;
  logic [MW-1:0]       last_owner;
  logic [MW-1:0]       hmaster_data;
  logic [HW-1:0]       hold_cnt;

  logic                found;
  logic [MW-1:0]       winner;
  logic [MW-1:0]       sel;
  int unsigned         idx;
  logic                others_req;
  logic                hold_done;
  logic                rearb;

  // last_owner always equals the current owner while in StOwn, so it serves as
  // the round-robin base in both states.
  always_comb begin
    found  = 1'b0;
    winner = '0;
    idx    = 0;
    sel    = '0;
    for (int i = 0; i < MAT_NUM; i++) begin
      idx = (32'(last_owner) + 32'd1 + 32'(i)) % MAT_NUM;
      sel = MW'(idx);
      if (!found && hbusreq[sel]) begin
        found  = 1'b1;
        winner = sel;
      end
    end
  end

  always_comb begin
    others_req = |(hbusreq & ~hgrant);
    hold_done  = (hold_cnt == HW'(MAX_HOLD - 1));
    rearb      = !hbusreq[hmaster] || (hold_done && others_req);
  end

  always_ff @(posedge hclk) begin
    if (hrst) begin
      state        <= StPark;
      hgrant       <= '0;
      hmaster      <= '0;
      hmaster_data <= '0;
      hold_cnt     <= '0;
      last_owner   <= MW'(MAT_NUM - 1);
    end else if (hready) begin
      hmaster_data <= hmaster;
      unique case (state)
        StPark: begin
          if (found) begin
            state      <= StOwn;
            hgrant     <= {{(MAT_NUM - 1){1'b0}}, 1'b1} << winner;
            hmaster    <= winner;
            last_owner <= winner;
            hold_cnt   <= '0;
          end
        end
        StOwn: begin
          if (rearb) begin
            hold_cnt <= '0;
            if (found) begin
              hgrant     <= {{(MAT_NUM - 1){1'b0}}, 1'b1} << winner;
              hmaster    <= winner;
              last_owner <= winner;
            end else begin
              state  <= StPark;
              hgrant <= '0;
            end
          end else if (!hold_done) begin
            hold_cnt <= hold_cnt + 1'b1;
          end
        end
        default: state <= StPark;
      endcase
    end
  end

  always_comb begin
    haddr  = haddr_m[hmaster];
    hwrite = hwrite_m[hmaster];
    htrans = (state == StOwn) ? htrans_m[hmaster] : 2'b00;
    hwdata = hwdata_m[hmaster_data];
  end

endmodule

// File: tb/tb_ahb_arbiter.sv
// Self-checking bench for ahb_arbiter: directed scenarios followed by randomized traffic,
// all compared against an integer-level arbitration model.
module tb_ahb_arbiter;

  localparam int N     = 4;
  localparam int MHOLD = 16;

  logic        hclk = 1'b0;
  logic        hrst;
  logic [3:0]  hbusreq;
  logic [15:0] haddr_m  [0:3];
  logic [1:0]  htrans_m [0:3];
  logic [3:0]  hwrite_m;
  logic [31:0] hwdata_m [0:3];
  logic        hready;
  logic [3:0]  hgrant;
  logic [1:0]  hmaster;
  logic [15:0] haddr;
  logic [1:0]  htrans;
  logic        hwrite;
  logic [31:0] hwdata;

  int checks = 0;
  int errors = 0;

  // Reference model: owner index (-1 when parked), address-phase and data-phase masters.
  int m_own, m_mstr, m_mdata, m_last, m_hold;

  ahb_arbiter #(
    .ADDR_WIDTH(16),
    .DATA_WIDTH(32),
    .MAT_NUM   (N),
    .MAX_HOLD  (MHOLD)
  ) dut (
    .hclk    (hclk),
    .hrst    (hrst),
    .hbusreq (hbusreq),
    .haddr_m (haddr_m),
    .htrans_m(htrans_m),
    .hwrite_m(hwrite_m),
    .hwdata_m(hwdata_m),
    .hready  (hready),
    .hgrant  (hgrant),
    .hmaster (hmaster),
    .haddr   (haddr),
    .htrans  (htrans),
    .hwrite  (hwrite),
    .hwdata  (hwdata)
  );

  always #5 hclk = ~hclk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic int rr_pick(input int start, input logic [3:0] req);
    for (int k = 0; k < N; k++) begin
      if (req[(start + k) % N]) return (start + k) % N;
    end
    return -1;
  endfunction

  task automatic model_edge();
    int w;
    int others;
    if (hrst) begin
      m_own = -1; m_mstr = 0; m_mdata = 0; m_last = N - 1; m_hold = 0;
    end else if (hready) begin
      m_mdata = m_mstr;
      if (m_own < 0) begin
        w = rr_pick(m_last + 1, hbusreq);
        if (w >= 0) begin
          m_own = w; m_mstr = w; m_last = w; m_hold = 0;
        end
      end else begin
        others = 0;
        for (int j = 0; j < N; j++) if (j != m_own && hbusreq[j]) others = 1;
        if (!hbusreq[m_own] || (m_hold == MHOLD - 1 && others == 1)) begin
          w = rr_pick(m_own + 1, hbusreq);
          m_hold = 0;
          if (w < 0) m_own = -1;
          else begin
            m_own = w; m_mstr = w; m_last = w;
          end
        end else if (m_hold < MHOLD - 1) begin
          m_hold++;
        end
      end
    end
  endtask

  task automatic check_all();
    chk("hgrant", 32'(hgrant), (m_own < 0) ? 32'd0 : (32'd1 << m_own));
    chk("hmaster", 32'(hmaster), 32'(m_mstr));
    chk("haddr", 32'(haddr), 32'(haddr_m[m_mstr]));
    chk("hwrite", 32'(hwrite), 32'(hwrite_m[m_mstr]));
    chk("htrans", 32'(htrans), (m_own < 0) ? 32'd0 : 32'(htrans_m[m_mstr]));
    chk("hwdata", 32'(hwdata), hwdata_m[m_mdata]);
  endtask

  task automatic step();
    @(posedge hclk);
    model_edge();
    #1;
    check_all();
  endtask

  initial begin
    int cnt;
    hrst = 1'b1; hbusreq = '0; hready = 1'b1; hwrite_m = '0;
    for (int i = 0; i < N; i++) begin
      haddr_m[i]  = 16'h1000 * 16'(i + 1);
      htrans_m[i] = 2'b10;
      hwdata_m[i] = 32'hD000_0000 + 32'(i);
    end
    m_own = -1; m_mstr = 0; m_mdata = 0; m_last = N - 1; m_hold = 0;

    // Reset state
    step(); step();
    chk("rst_hgrant", 32'(hgrant), 32'd0);
    chk("rst_htrans", 32'(htrans), 32'd0);
    chk("rst_hmaster", 32'(hmaster), 32'd0);

    // All request; owners drop in turn
    hrst = 1'b0; hbusreq = 4'b1111;
    step(); chk("rr_g0", 32'(hgrant), 32'b0001);
    hbusreq = 4'b1110; step(); chk("rr_g1", 32'(hgrant), 32'b0010);
    hbusreq = 4'b1100; step(); chk("rr_g2", 32'(hgrant), 32'b0100);
    hbusreq = 4'b1000; step(); chk("rr_g3", 32'(hgrant), 32'b1000);

    // Hold limit: master 2 keeps requesting while master 0 waits
    hbusreq = 4'b0100; step(); chk("hold_start", 32'(hgrant), 32'b0100);
    hbusreq = 4'b0101; htrans_m[2] = 2'b11;
    cnt = 1;
    for (int t = 0; t < 40; t++) begin
      step();
      if (hgrant != 4'b0100) break;
      cnt++;
    end
    chk("hold_beats", 32'(cnt), 32'd16);
    chk("hold_next", 32'(hgrant), 32'b0001);

    // Wait states freeze grant and phases
    hbusreq = 4'b0010; step(); chk("ws_g1", 32'(hgrant), 32'b0010);
    haddr_m[1] = 16'h0400; hwrite_m[1] = 1'b1; hwdata_m[1] = 32'hA5A5_0001;
    step();
    hready = 1'b0; hbusreq = 4'b0000;
    for (int t = 0; t < 3; t++) begin
      step();
      chk("ws_grant", 32'(hgrant), 32'b0010);
      chk("ws_addr", 32'(haddr), 32'h0400);
      chk("ws_data", hwdata, 32'hA5A5_0001);
    end

    // Grant 1 -> 3: address from 3, data still from 1
    hready = 1'b1; hbusreq = 4'b1000; haddr_m[3] = 16'h0C30;
    step();
    chk("ph_grant", 32'(hgrant), 32'b1000);
    chk("ph_addr", 32'(haddr), 32'h0C30);
    chk("ph_data", hwdata, 32'hA5A5_0001);

    // Park then single request
    hbusreq = 4'b0000; step();
    chk("park_grant", 32'(hgrant), 32'd0);
    chk("park_htrans", 32'(htrans), 32'd0);
    step();
    hbusreq = 4'b0100; step(); chk("unpark_g2", 32'(hgrant), 32'b0100);

    // Reset during master-3 burst
    hbusreq = 4'b1000; step(); chk("burst_g3", 32'(hgrant), 32'b1000);
    htrans_m[3] = 2'b11; step();
    hrst = 1'b1; step();
    chk("mid_rst_grant", 32'(hgrant), 32'd0);
    chk("mid_rst_htrans", 32'(htrans), 32'd0);
    chk("mid_rst_hmaster", 32'(hmaster), 32'd0);
    hrst = 1'b0; hbusreq = 4'b1001; step();
    chk("post_rst_g0", 32'(hgrant), 32'b0001);

    // Randomized traffic
    for (int c = 0; c < 600; c++) begin
      for (int i = 0; i < N; i++) begin
        if ($urandom_range(0, 3) == 0) hbusreq[i] = ~hbusreq[i];
        haddr_m[i]  = 16'($urandom);
        htrans_m[i] = 2'($urandom);
        hwrite_m[i] = 1'($urandom);
        hwdata_m[i] = $urandom;
      end
      hready = ($urandom_range(0, 3) != 0);
      hrst   = ($urandom_range(0, 99) == 0);
      step();
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
